router_pkt_src: RTL and testbench

- Packet transmitter that drives the router's input side (pkt_valid, data_in) with well-formed packets: header {len,addr}, len payload bytes, then an XOR parity byte.
- Payload comes from an internal 8-bit LFSR, so benches can predict every byte.
- Honours the router's busy stall signal and can inject a corrupted parity byte to exercise the router's error path.
- Used as the stimulus source in router-level benches and as a built-in self-test traffic generator.

---
 rtl/router_pkt_src.sv | 148 ++++++++++++++
 tb/tb_router_pkt_src.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/router_pkt_src.sv
// Packet source for the router input side: sends a {len,addr} header, len LFSR payload bytes, then an XOR parity byte.
// The source honours the busy stall and can corrupt the parity byte on request.
module router_pkt_src #(
  parameter logic [7:0] SEED       = 8'hA5,
  parameter int         GAP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [1:0]  addr,
  input  logic [5:0]  len,
  input  logic        bad_parity,
  input  logic        busy,
  output logic        pkt_valid,
  output logic [7:0]  data_out,
  output logic        tx_ready,
  output logic        done,
  output logic        start_rej,
  output logic [15:0] pkt_count
);

  typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, PARITY, GAP} state_t;

  localparam logic [3:0] GAP_INIT = 4'(GAP_CYCLES);

  state_t      state, state_n;
  logic [7:0]  lfsr, lfsr_n, parity, parity_n, data_n;
  logic [5:0]  cnt, cnt_n, len_q, len_n;
  logic [1:0]  addr_q, addr_n;
  logic        bad_q, bad_n;
  logic [3:0]  gap_cnt, gap_n;
  logic        pkt_valid_n, done_n, rej_n;

  function automatic logic [7:0] lfsr_step(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      lfsr      <= SEED;
      parity    <= '0;
      cnt       <= '0;
      len_q     <= '0;
      addr_q    <= '0;
      bad_q     <= 1'b0;
      gap_cnt   <= '0;
      pkt_valid <= 1'b0;
      data_out  <= '0;
      done      <= 1'b0;
      start_rej <= 1'b0;
    end else begin
      state     <= state_n;
      lfsr      <= lfsr_n;
      parity    <= parity_n;
      cnt       <= cnt_n;
      len_q     <= len_n;
      addr_q    <= addr_n;
      bad_q     <= bad_n;
      gap_cnt   <= gap_n;
      pkt_valid <= pkt_valid_n;
      data_out  <= data_n;
      done      <= done_n;
      start_rej <= rej_n;
    end
  end

  // Only written on packet completion, so the count holds its value between packets.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      pkt_count <= '0;
    else if (state == GAP && gap_cnt == 4'd1)
      pkt_count <= pkt_count + 16'd1;
  end

  assign tx_ready = (state == IDLE);

  always_comb begin
    state_n     = state;
    lfsr_n      = lfsr;
    parity_n    = parity;
    cnt_n       = cnt;
    len_n       = len_q;
    addr_n      = addr_q;
    bad_n       = bad_q;
    gap_n       = gap_cnt;
    pkt_valid_n = pkt_valid;
    data_n      = data_out;
    done_n      = 1'b0;
    rej_n       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (len != 6'd0 && addr != 2'd3) begin
            state_n     = HEADER;
            len_n       = len;
            addr_n      = addr;
            bad_n       = bad_parity;
            pkt_valid_n = 1'b1;
            data_n      = {len, addr};
          end else begin
            rej_n = 1'b1;
          end
        end
      end
      HEADER: begin
        if (!busy) begin
          state_n  = PAYLOAD;
          parity_n = data_out;
          cnt_n    = '0;
          data_n   = lfsr;
        end
      end
      // The LFSR always holds the byte currently on data_out during PAYLOAD.
      PAYLOAD: begin
        if (!busy) begin
          parity_n = parity ^ data_out;
          lfsr_n   = lfsr_step(lfsr);
          cnt_n    = cnt + 6'd1;
          if (cnt == len_q - 6'd1) begin
            state_n     = PARITY;
            pkt_valid_n = 1'b0;
            data_n      = (parity ^ data_out) ^ {8{bad_q}};
          end else begin
            data_n = lfsr_step(lfsr);
          end
        end
      end
      PARITY: begin
        if (!busy) begin
          state_n = GAP;
          data_n  = '0;
          gap_n   = GAP_INIT;
        end
      end
      GAP: begin
        if (gap_cnt == 4'd1) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          gap_n = gap_cnt - 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_router_pkt_src.sv
// Directed bench for router_pkt_src: a model builds each packet's byte stream into a queue and
// the bytes are popped and compared as the source emits them.
module tb_router_pkt_src;

  logic        clk = 1'b0;
  logic        rstn, start, bad_parity, busy;
  logic [1:0]  addr;
  logic [5:0]  len;
  logic        pkt_valid, tx_ready, done, start_rej;
  logic [7:0]  data_out;
  logic [15:0] pkt_count;

  int checks = 0;
  int failures = 0;

  logic [8:0]  exp_q[$];
  logic [7:0]  model_lfsr;
  logic [15:0] model_count;

  always #5 clk = ~clk;

  router_pkt_src #(.SEED(8'hA5), .GAP_CYCLES(2)) dut (
    .clk(clk), .rstn(rstn), .start(start), .addr(addr), .len(len),
    .bad_parity(bad_parity), .busy(busy), .pkt_valid(pkt_valid),
    .data_out(data_out), .tx_ready(tx_ready), .done(done),
    .start_rej(start_rej), .pkt_count(pkt_count)
  );

  function automatic logic [7:0] model_step(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

  task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Expected stream entries are {pkt_valid, data_out}.
  task automatic push_packet(input logic [1:0] a, input logic [5:0] l, input logic b);
    logic [7:0] p;
    p = {l, a};
    exp_q.push_back({1'b1, p});
    for (int i = 0; i < int'(l); i++) begin
      exp_q.push_back({1'b1, model_lfsr});
      p = p ^ model_lfsr;
      model_lfsr = model_step(model_lfsr);
    end
    exp_q.push_back({1'b0, p ^ {8{b}}});
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_pkt_valid"}, {15'd0, pkt_valid}, 16'd0);
    check_output({tag, "_data_out"}, {8'd0, data_out}, 16'd0);
    check_output({tag, "_tx_ready"}, {15'd0, tx_ready}, 16'd1);
    check_output({tag, "_done"}, {15'd0, done}, 16'd0);
    check_output({tag, "_start_rej"}, {15'd0, start_rej}, 16'd0);
    check_output({tag, "_pkt_count"}, pkt_count, 16'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    rstn = 1'b1;
    model_lfsr  = 8'hA5;
    model_count = 16'd0;
  endtask

  // Index values of -1 disable the stall, abort and mid-packet start options.
  task automatic apply_stimulus(input logic [1:0] a, input logic [5:0] l, input logic b,
                                input int stall_idx, input int abort_idx, input int poke_idx);
    logic [8:0] e;
    int idx;
    idx = 0;
    @(negedge clk);
    start = 1'b1; addr = a; len = l; bad_parity = b;
    push_packet(a, l, b);
    @(negedge clk);
    start = 1'b0; addr = 2'd3; len = 6'd0; bad_parity = ~b;
    check_output("tx_ready_in_pkt", {15'd0, tx_ready}, 16'd0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_output("pkt_valid", {15'd0, pkt_valid}, {15'd0, e[8]});
      check_output("data_out", {8'd0, data_out}, {8'd0, e[7:0]});
      check_output("no_rej_in_pkt", {15'd0, start_rej}, 16'd0);
      if (idx == abort_idx) begin
        rstn = 1'b0;
        #1;
        check_output("abort_pkt_valid", {15'd0, pkt_valid}, 16'd0);
        check_output("abort_data_out", {8'd0, data_out}, 16'd0);
        check_output("abort_tx_ready", {15'd0, tx_ready}, 16'd1);
        exp_q.delete();
        @(negedge clk);
        rstn = 1'b1;
        model_lfsr  = 8'hA5;
        model_count = 16'd0;
        return;
      end
      if (idx == stall_idx) begin
        busy = 1'b1;
        repeat (4) begin
          @(negedge clk);
          check_output("stall_data", {8'd0, data_out}, {8'd0, e[7:0]});
          check_output("stall_valid", {15'd0, pkt_valid}, {15'd0, e[8]});
        end
        busy = 1'b0;
      end
      if (idx == poke_idx) begin
        start = 1'b1; addr = 2'd1; len = 6'd1;
      end
      @(negedge clk);
      start = 1'b0;
      idx++;
    end
    check_output("gap1_done", {15'd0, done}, 16'd0);
    check_output("gap1_valid", {15'd0, pkt_valid}, 16'd0);
    check_output("gap1_data", {8'd0, data_out}, 16'd0);
    check_output("gap1_tx_ready", {15'd0, tx_ready}, 16'd0);
    @(negedge clk);
    check_output("gap2_done", {15'd0, done}, 16'd0);
    @(negedge clk);
    model_count = model_count + 16'd1;
    check_output("done_pulse", {15'd0, done}, 16'd1);
    check_output("idle_tx_ready", {15'd0, tx_ready}, 16'd1);
    check_output("pkt_count", pkt_count, model_count);
    @(negedge clk);
    check_output("done_one_cycle", {15'd0, done}, 16'd0);
  endtask

  task automatic reject_start(input logic [1:0] a, input logic [5:0] l, input string tag);
    @(negedge clk);
    start = 1'b1; addr = a; len = l; bad_parity = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check_output({tag, "_rej"}, {15'd0, start_rej}, 16'd1);
    check_output({tag, "_valid"}, {15'd0, pkt_valid}, 16'd0);
    check_output({tag, "_tx_ready"}, {15'd0, tx_ready}, 16'd1);
    check_output({tag, "_count"}, pkt_count, model_count);
    @(negedge clk);
    check_output({tag, "_rej_clear"}, {15'd0, start_rej}, 16'd0);
    check_output({tag, "_still_idle"}, {15'd0, tx_ready}, 16'd1);
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; bad_parity = 1'b0; busy = 1'b0;
    addr = 2'd0; len = 6'd0;
    model_lfsr = 8'hA5; model_count = 16'd0;
    $display("[TB] start");

    do_reset();
    apply_stimulus(2'd2, 6'd5, 1'b0, -1, -1, -1);

    do_reset();
    apply_stimulus(2'd1, 6'd1, 1'b0, -1, -1, -1);
    do_reset();
    apply_stimulus(2'd1, 6'd1, 1'b1, -1, -1, -1);

    do_reset();
    apply_stimulus(2'd2, 6'd5, 1'b0, 2, -1, -1);

    reject_start(2'd1, 6'd0, "rej_len0");
    reject_start(2'd3, 6'd4, "rej_addr3");

    apply_stimulus(2'd2, 6'd5, 1'b0, -1, 3, -1);
    check_reset_outputs("after_abort");
    apply_stimulus(2'd1, 6'd1, 1'b0, -1, -1, -1);

    apply_stimulus(2'd2, 6'd3, 1'b0, -1, -1, 2);
    apply_stimulus(2'd0, 6'd2, 1'b0, -1, -1, -1);

    apply_stimulus(2'd1, 6'd63, 1'b0, -1, -1, -1);

    @(negedge clk);
    force dut.pkt_count = 16'hFFFF;
    @(negedge clk);
    release dut.pkt_count;
    model_count = 16'hFFFF;
    check_output("count_preload", pkt_count, 16'hFFFF);
    apply_stimulus(2'd1, 6'd2, 1'b1, -1, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
